// File: rtl/pc_sequencer.sv
// Program counter and instruction-fetch sequencer: picks the next PC from
// exception/jump/branch/buffered-redirect/sequential sources and drives imem fetch.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_0080
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        exc,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    typedef enum logic {BOOT, FETCH} state_t;

    state_t      state, state_next;
    logic [1:0]  pend_lvl, cur_lvl, sel_lvl;
    logic [31:0] pend_addr, cur_addr, sel_addr;
    logic        done;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    always_ff @(posedge clock) begin
        if (!reset) state <= BOOT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        case (state)
            BOOT:  state_next = FETCH;
            FETCH: begin
                state_next = FETCH;
                imem_req   = !stall;
            end
        endcase
    end

    assign done = imem_req && imem_ready;

    // Redirect presented this cycle: exception outranks jump and branch.
    always_comb begin
        cur_lvl  = 2'd0;
        cur_addr = 32'd0;
        if (exc) begin
            cur_lvl  = 2'd2;
            cur_addr = EXC_VEC;
        end else if (jump) begin
            cur_lvl  = 2'd1;
            cur_addr = jump_target;
        end else if (branch_taken) begin
            cur_lvl  = 2'd1;
            cur_addr = branch_target;
        end
    end

    // A fresh redirect beats a buffered one of the same level.
    always_comb begin
        sel_lvl  = pend_lvl;
        sel_addr = pend_addr;
        if (cur_lvl != 2'd0 && cur_lvl >= pend_lvl) begin
            sel_lvl  = cur_lvl;
            sel_addr = word_align(cur_addr);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc        <= RESET_VEC;
            pend_lvl  <= 2'd0;
            pend_addr <= 32'd0;
        end else if (done) begin
            pc        <= (sel_lvl != 2'd0) ? sel_addr : pc_plus4;
            pend_lvl  <= 2'd0;
            pend_addr <= 32'd0;
        end else if (sel_lvl != 2'd0) begin
            pend_lvl  <= sel_lvl;
            pend_addr <= sel_addr;
        end
    end

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table followed by random traffic
// compared against a cycle-level behavioural model.
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset, stall, exc, jump, branch_taken, imem_ready;
    logic [31:0] jump_target, branch_target;
    logic        imem_req;
    logic [31:0] imem_addr, pc, pc_plus4;

    int n_chk  = 0;
    int n_fail = 0;

    pc_sequencer dut (
        .clock(clock), .reset(reset), .stall(stall), .exc(exc), .jump(jump),
        .jump_target(jump_target), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_ready(imem_ready),
        .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc), .pc_plus4(pc_plus4)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst_n, stl, ex, jmp, br, rdy;
        logic [31:0] jt, bt;
        logic        chk;
        logic [31:0] exp_pc;
        logic        exp_req;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, s, e, j, b, rd, input logic [31:0] jt, bt);
        reset = r; stall = s; exc = e; jump = j; branch_taken = b;
        imem_ready = rd; jump_target = jt; branch_target = bt;
    endtask

    task automatic add(input logic r, s, e, j, b, rd, input logic [31:0] jt, bt,
                       input logic c, input logic [31:0] p, input logic q);
        vec_t v;
        v.rst_n = r; v.stl = s; v.ex = e; v.jmp = j; v.br = b; v.rdy = rd;
        v.jt = jt; v.bt = bt; v.chk = c; v.exp_pc = p; v.exp_req = q;
        vecs.push_back(v);
    endtask

    // Behavioural reference state
    logic [31:0] m_pc, m_pend_addr;
    int          m_pend_lvl;
    bit          m_boot, m_known;

    task automatic model_step();
        int          lvl;
        logic [31:0] tgt;
        bit          fetched;
        if (!reset) begin
            m_pc = 32'h0; m_boot = 1; m_pend_lvl = 0; m_pend_addr = 0; m_known = 1;
            return;
        end
        fetched = !m_boot && !stall && imem_ready;
        lvl = 0; tgt = 0;
        if (exc)               begin lvl = 2; tgt = 32'h80; end
        else if (jump)         begin lvl = 1; tgt = jump_target   & ~32'd3; end
        else if (branch_taken) begin lvl = 1; tgt = branch_target & ~32'd3; end
        if (m_pend_lvl > lvl) begin lvl = m_pend_lvl; tgt = m_pend_addr; end
        if (fetched) begin
            m_pc = (lvl > 0) ? tgt : m_pc + 32'd4;
            m_pend_lvl = 0; m_pend_addr = 0;
        end else if (lvl > 0) begin
            m_pend_lvl = lvl; m_pend_addr = tgt;
        end
        m_boot = 0;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        // reset, then sequential fetch 0,4,8,12
        add(0,0,0,0,0,1, 0,0, 0, 0,     0);
        add(0,0,0,0,0,1, 0,0, 1, 0,     0);
        add(1,0,0,0,0,1, 0,0, 1, 0,     0);
        add(1,0,0,0,0,1, 0,0, 1, 0,     1);
        add(1,0,0,0,0,1, 0,0, 1, 4,     1);
        add(1,0,0,0,0,1, 0,0, 1, 8,     1);
        add(1,0,0,0,0,1, 0,0, 1, 12,    1);
        // jump back to 8, then branch buffered across three wait cycles
        add(1,0,0,1,0,1, 8,0, 1, 16,    1);
        add(1,0,0,0,1,0, 0,32'h40, 1, 8, 1);
        add(1,0,0,0,0,0, 0,0, 1, 8,     1);
        add(1,0,0,0,0,0, 0,0, 1, 8,     1);
        add(1,0,0,0,0,1, 0,0, 1, 8,     1);
        add(1,0,0,0,0,0, 0,0, 1, 32'h40, 1);
        // stalled jump then exception; exception wins
        add(1,1,0,1,0,1, 32'h100,0, 1, 32'h40, 0);
        add(1,1,1,0,0,1, 0,0, 1, 32'h40, 0);
        add(1,0,0,0,0,1, 0,0, 1, 32'h40, 1);
        add(1,0,0,0,0,1, 0,0, 1, 32'h80, 1);
        // all three redirects together
        add(1,0,1,1,1,1, 32'h200,32'h300, 1, 32'h84, 1);
        // misaligned branch target
        add(1,0,0,0,1,1, 0,32'h123, 1, 32'h80, 1);
        add(1,0,0,0,0,0, 0,0, 1, 32'h120, 1);
        // reset while a jump is pending
        add(1,0,0,1,0,0, 32'h500,0, 1, 32'h120, 1);
        add(0,0,0,0,0,0, 0,0, 1, 32'h120, 1);
        add(1,0,0,0,0,1, 0,0, 1, 0,     0);
        add(1,0,0,0,0,1, 0,0, 1, 0,     1);
        add(1,0,0,0,0,0, 0,0, 1, 4,     1);
        // wrap at top of address space
        add(1,0,0,1,0,1, 32'hFFFF_FFFF,0, 1, 4, 1);
        add(1,0,0,0,0,1, 0,0, 1, 32'hFFFF_FFFC, 1);
        add(0,0,0,0,0,0, 0,0, 1, 0,     1);
        // redirect during BOOT is buffered
        add(1,0,0,0,1,1, 0,32'h44, 1, 0, 0);
        add(1,0,0,0,0,1, 0,0, 1, 0,     1);
        add(1,0,0,0,0,0, 0,0, 1, 32'h44, 1);

        @(posedge clock); #1;
        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].stl, vecs[i].ex, vecs[i].jmp, vecs[i].br,
                  vecs[i].rdy, vecs[i].jt, vecs[i].bt);
            @(negedge clock);
            if (vecs[i].chk) begin
                check("pc",        i, pc,               vecs[i].exp_pc);
                check("imem_addr", i, imem_addr,        vecs[i].exp_pc);
                check("pc_plus4",  i, pc_plus4,         vecs[i].exp_pc + 32'd4);
                check("imem_req",  i, {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
            end
            @(posedge clock); #1;
        end

        // random traffic against the model; first cycle is a forced reset
        m_known = 0; m_pc = 0; m_boot = 1; m_pend_lvl = 0; m_pend_addr = 0;
        for (int c = 0; c < 3000; c++) begin
            drive((c == 0) ? 1'b0 : ($urandom_range(99) >= 3),
                  $urandom_range(99) < 25, $urandom_range(99) < 8,
                  $urandom_range(99) < 15, $urandom_range(99) < 15,
                  $urandom_range(99) < 60, $urandom(), $urandom());
            if (c % 500 == 1) jump_target = 32'hFFFF_FFFC;
            @(negedge clock);
            if (m_known) begin
                check("rnd_pc",       c, pc,        m_pc);
                check("rnd_addr",     c, imem_addr, m_pc);
                check("rnd_plus4",    c, pc_plus4,  m_pc + 32'd4);
                check("rnd_imem_req", c, {31'd0, imem_req}, {31'd0, (!m_boot && !stall)});
            end
            model_step();
            @(posedge clock); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
